serial_ripple_subtractor: RTL and testbench

Bit-serial counterpart of the team's parallel ripple-carry adder. It computes DIFF = A - B - BIN using one full-subtractor cell and a registered borrow, processing one bit per clock from LSB to MSB. Operands are accepted and results are returned over valid/ready handshakes. The block sits wherever area matters more than latency, e.g. fault-simulator test designs that exercise sequential fault propagation.

---
 rtl/serial_ripple_subtractor.sv | 107 ++++++++++
 tb/tb_serial_ripple_subtractor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: computes {BOUT, DIFF} = A - B - BIN one bit per clock,
// LSB first. It uses a single full-subtractor cell and a registered borrow.
// Operands arrive and results leave over valid/ready handshakes.
// Operand ports use [0:WIDTH-1] ordering: index 0 is the MSB, index WIDTH-1 the LSB.
module serial_ripple_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:WIDTH-1] A,
   input  logic [0:WIDTH-1] B,
   input  logic             BIN,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:WIDTH-1] DIFF,
   output logic             BOUT
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [0:WIDTH-1] a_sr;      // minuend, shifted toward the LSB end each RUN cycle
   logic [0:WIDTH-1] b_sr;      // subtrahend, shifted the same way
   logic [0:WIDTH-1] part;      // partial difference assembled bit by bit
   logic             br;        // borrow into the bit being processed
   logic [CW-1:0]    cnt;       // bits already processed

   logic             a_bit;
   logic             b_bit;
   logic             d;
   logic             br_next;
   logic [CW-1:0]    idx;
   logic [0:WIDTH-1] part_next;

   assign in_ready = (state == IDLE) && rst_n;

   // Full-subtractor cell on the current LSB and the partial result with the new bit inserted
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      part_next = part;
      a_bit     = a_sr[WIDTH-1];
      b_bit     = b_sr[WIDTH-1];
      d         = a_bit ^ b_bit ^ br;
      br_next   = (~a_bit & b_bit) | (~a_bit & br) | (b_bit & br);
      idx       = LAST - cnt;
      part_next[idx] = d;
   end

   // Control FSM, serial datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state     <= IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         part      <= '0;
         br        <= 1'b0;
         cnt       <= '0;
         DIFF      <= '0;
         BOUT      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  br    <= BIN;
                  part  <= '0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               br   <= br_next;
               part <= part_next;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // The final bit goes straight into DIFF so the result appears in one update.
                  DIFF      <= part_next;
                  BOUT      <= br_next;
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (WIDTH=4).
// A cycle-level behavioural model predicts handshakes and {BOUT,DIFF}. The
// model uses plain integer subtraction. Directed vectors pin the model with
// hand-computed literals.
module tb_serial_ripple_subtractor;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [0:WIDTH-1] A = '0;
   logic [0:WIDTH-1] B = '0;
   logic             BIN = 1'b0;
   logic             out_valid;
   logic             out_ready;
   logic [0:WIDTH-1] DIFF;
   logic             BOUT;

   logic             ready_fix = 1'b1;
   logic             rand_ready = 1'b0;
   logic             rnd_bit = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   int n_done = 0;

   assign out_ready = rand_ready ? rnd_bit : ready_fix;

   serial_ripple_subtractor #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .BIN(BIN),
      .out_valid(out_valid), .out_ready(out_ready),
      .DIFF(DIFF), .BOUT(BOUT)
   );

   always #5 clk = ~clk;

   // Random downstream backpressure, changed just after each rising edge
   always @(posedge clk) begin
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: operation in flight, cycles elapsed, last delivered result
   logic       m_busy = 1'b0;
   logic       m_done = 1'b0;
   int         m_cnt = 0;
   logic [4:0] m_pend = '0;
   logic [4:0] m_res = '0;
   int         m_t;

   // Compare process: checks outputs every falling edge, then predicts the next edge
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_out_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 0);
         check("rst_diff", DIFF, 0);
         check("rst_bout", BOUT, 0);
         m_busy = 1'b0;
         m_done = 1'b0;
         m_res  = '0;
      end else begin
         check("out_valid", out_valid, m_done);
         check("in_ready", in_ready, !(m_busy || m_done));
         check("diff", DIFF, m_res[3:0]);
         check("bout", BOUT, m_res[4]);
         if (m_done) begin
            if (out_ready) begin
               m_done = 1'b0;
               n_done++;
            end
         end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == WIDTH) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_res  = m_pend;
            end
         end else if (in_valid) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_t    = int'(A) - int'(B) - int'(BIN);
            m_pend = m_t[4:0];
         end
      end
   end

   // Present operands, wait for acceptance, then scramble the operand lines.
   // Entry and exit are both at posedge+1.
   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic bin);
      int t;
      A = a; B = b; BIN = bin; in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 100) begin
         @(posedge clk); #1; t++;
      end
      check("accept_wait", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      A = 4'($urandom); B = 4'($urandom); BIN = 1'($urandom);
   endtask

   // Full directed operation with out_ready high and literal result checks
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         input logic [3:0] ed, input logic eb, input string nm);
      int lat;
      ready_fix = 1'b1;
      send(a, b, bin);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      check({nm, "_latency"}, lat, WIDTH);
      check({nm, "_diff"}, DIFF, ed);
      check({nm, "_bout"}, BOUT, eb);
      @(posedge clk); #1;
      check({nm, "_in_ready_after"}, in_ready, 1);
      check({nm, "_out_valid_after"}, out_valid, 0);
   endtask

   initial begin
      int lat;
      int done0;
      logic [8:0] v;

      // Reset values, then release
      #1;
      check("init_rst_in_ready", in_ready, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("release_in_ready", in_ready, 1);

      // Basic and borrow-chain vectors
      run_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, "basic");
      run_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, "neg");
      run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, "zero_bin");
      run_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, "ones_bin");

      // Backpressure: hold out_ready low while a new operand waits
      ready_fix = 1'b0;
      send(4'b0110, 4'b0001, 1'b0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      check("bp_latency", lat, WIDTH);
      A = 4'b1111; B = 4'b0000; BIN = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_diff", DIFF, 4'b0101);
         check("bp_hold_bout", BOUT, 0);
         check("bp_hold_in_ready", in_ready, 0);
      end
      ready_fix = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", out_valid, 0);
      check("bp_release_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_second_accept", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      check("bp_second_latency", lat, WIDTH);
      check("bp_second_diff", DIFF, 4'b1111);
      check("bp_second_bout", BOUT, 0);
      @(posedge clk); #1;

      // Abort: reset two cycles into RUN
      send(4'b1000, 4'b0001, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 0);
      check("abort_diff", DIFF, 0);
      check("abort_bout", BOUT, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("abort_release_in_ready", in_ready, 1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("abort_no_pulse", out_valid, 0);
      end
      run_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, "post_abort");

      // Exhaustive regression with random gaps and random backpressure
      done0 = n_done;
      rand_ready = 1'b1;
      for (int i = 0; i < 512; i++) begin
         v = 9'(i);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         send(v[3:0], v[7:4], v[8]);
      end
      rand_ready = 1'b0;
      ready_fix = 1'b1;
      lat = 0;
      while (!in_ready && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      check("drain_in_ready", in_ready, 1);
      @(posedge clk); #1;
      check("regression_completed", n_done - done0, 512);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
